// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches 16-bit words over a req/ack port, strobes exec1
// for ALU opcodes, and resolves halt/jump/jump-if-carry locally.
module instr_sequencer #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       instr,
   output logic              exec1,
   output logic              carrystatus,
   input  logic              carryout,
   input  logic              carryen,
   output logic              halted
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   localparam logic [7:0] OP_HALT = 8'h00;
   localparam logic [7:0] OP_JMP  = 8'h01;
   localparam logic [7:0] OP_JC   = 8'h02;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [7:0]        op;
   logic              is_ctrl;

   assign op      = instr[15:8];
   assign is_ctrl = (op == OP_HALT) || (op == OP_JMP) || (op == OP_JC);

   // Outputs decode from registered state only, so no input-to-output paths.
   assign mem_addr = pc;
   assign mem_rd   = (state == FETCH);
   assign exec1    = (state == EXEC) && !is_ctrl;
   assign halted   = (state == HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= 16'h0000;
         carrystatus <= 1'b0;
      end else begin
         case (state)
            IDLE: if (run) state <= FETCH;
            FETCH: begin
               if (mem_ack) begin
                  instr <= mem_rdata;
                  state <= EXEC;
               end
            end
            EXEC: begin
               state <= run ? FETCH : IDLE;
               case (op)
                  OP_HALT: state <= HALT;
                  OP_JMP:  pc    <= instr[ADDR_W-1:0];
                  OP_JC:   pc    <= carrystatus ? instr[ADDR_W-1:0] : pc + 1'b1;
                  default: begin
                     pc <= pc + 1'b1;
                     if (carryen) carrystatus <= carryout;
                  end
               endcase
            end
            HALT: state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
